// File: rtl/enemy_bullet_drop.sv
// Enemy projectile engine: launches one bullet from a fixed spawn row, drops it
// one pixel per step tick, and reports a player hit or a floor miss. A cooldown
// then runs before the next shot is accepted.
module enemy_bullet_drop #(
  parameter int unsigned STEP_DIV = 250000,
  parameter int unsigned SPAWN_Y  = 80,
  parameter int unsigned FLOOR_Y  = 440,
  parameter int unsigned PLAYER_Y = 400,
  parameter int unsigned HIT_H    = 16,
  parameter int unsigned PLAYER_W = 32,
  parameter int unsigned COOLDOWN = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fire,
  input  logic [9:0] spawnX,
  input  logic [9:0] playerX,
  output logic [9:0] bulletPosX,
  output logic [9:0] bulletPosY,
  output logic       active,
  output logic       busy,
  output logic       hitPlayer,
  output logic       missed
);

  localparam int unsigned POS_W  = 10;
  localparam int unsigned CMP_W  = POS_W + 1;
  localparam int unsigned DIV_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int unsigned COOL_W = $clog2(COOLDOWN + 1);

  typedef enum logic [2:0] {
    IDLE,
    FALL,
    HIT,
    MISS,
    COOL
  } state_t;

  state_t              state, state_d;
  logic [DIV_W-1:0]    div, div_d;
  logic [COOL_W-1:0]   cool, cool_d;
  logic [POS_W-1:0]    posx_d, posy_d;
  logic                active_d, busy_d, hit_d, miss_d;

  logic                tick_c;
  logic [CMP_W-1:0]    y_next_c;
  logic                in_y_c, in_x_c, at_floor_c;

  // Step tick and hit-box / floor tests; 11-bit sums so nothing wraps at 1023
  assign tick_c     = (div == DIV_W'(STEP_DIV - 1));
  assign y_next_c   = {1'b0, bulletPosY} + CMP_W'(1);
  assign in_y_c     = (y_next_c >= CMP_W'(PLAYER_Y)) &&
                      (y_next_c <  CMP_W'(PLAYER_Y + HIT_H));
  assign in_x_c     = ({1'b0, bulletPosX} >= {1'b0, playerX}) &&
                      ({1'b0, bulletPosX} <  ({1'b0, playerX} + CMP_W'(PLAYER_W)));
  assign at_floor_c = (y_next_c == CMP_W'(FLOOR_Y));

  // Next-state and next-output logic
  always_comb begin
    state_d  = state;
    div_d    = div;
    cool_d   = cool;
    posx_d   = bulletPosX;
    posy_d   = bulletPosY;
    active_d = active;
    busy_d   = busy;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    case (state)
      IDLE: begin
        if (fire) begin
          posx_d   = spawnX;
          posy_d   = POS_W'(SPAWN_Y);
          div_d    = '0;
          active_d = 1'b1;
          busy_d   = 1'b1;
          state_d  = FALL;
        end
      end
      FALL: begin
        if (tick_c) begin
          div_d = '0;
          if (in_y_c && in_x_c) begin
            posy_d  = y_next_c[POS_W-1:0];
            hit_d   = 1'b1;
            state_d = HIT;
          end else if (at_floor_c) begin
            posy_d  = POS_W'(FLOOR_Y);
            miss_d  = 1'b1;
            state_d = MISS;
          end else begin
            posy_d  = y_next_c[POS_W-1:0];
          end
        end else begin
          div_d = div + DIV_W'(1);
        end
      end
      HIT, MISS: begin
        active_d = 1'b0;
        div_d    = '0;
        cool_d   = '0;
        state_d  = COOL;
      end
      COOL: begin
        if (tick_c) begin
          div_d = '0;
          if (cool == COOL_W'(COOLDOWN - 1)) begin
            cool_d  = '0;
            busy_d  = 1'b0;
            posy_d  = POS_W'(SPAWN_Y);
            state_d = IDLE;
          end else begin
            cool_d = cool + COOL_W'(1);
          end
        end else begin
          div_d = div + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      div        <= '0;
      cool       <= '0;
      bulletPosX <= '0;
      bulletPosY <= POS_W'(SPAWN_Y);
      active     <= 1'b0;
      busy       <= 1'b0;
      hitPlayer  <= 1'b0;
      missed     <= 1'b0;
    end else begin
      state      <= state_d;
      div        <= div_d;
      cool       <= cool_d;
      bulletPosX <= posx_d;
      bulletPosY <= posy_d;
      active     <= active_d;
      busy       <= busy_d;
      hitPlayer  <= hit_d;
      missed     <= miss_d;
    end
  end

endmodule

// File: tb/tb_enemy_bullet_drop.sv
// Bench for enemy_bullet_drop: table vectors, hand-written corner sequences and
// random shots checked against a step-by-step trajectory model.
module tb_enemy_bullet_drop;

  localparam int STEP_DIV = 4;
  localparam int SPAWN_Y  = 100;
  localparam int FLOOR_Y  = 110;
  localparam int PLAYER_Y = 106;
  localparam int HIT_H    = 4;
  localparam int PLAYER_W = 8;
  localparam int COOLDOWN = 3;
  localparam int COOL_CYC = COOLDOWN * STEP_DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic       fire;
  logic [9:0] spawnX, playerX;
  logic [9:0] bulletPosX, bulletPosY;
  logic       active, busy, hitPlayer, missed;

  int checks = 0;
  int errors = 0;

  enemy_bullet_drop #(
    .STEP_DIV(STEP_DIV), .SPAWN_Y(SPAWN_Y), .FLOOR_Y(FLOOR_Y),
    .PLAYER_Y(PLAYER_Y), .HIT_H(HIT_H), .PLAYER_W(PLAYER_W), .COOLDOWN(COOLDOWN)
  ) dut (
    .clk(clk), .reset(reset), .fire(fire), .spawnX(spawnX), .playerX(playerX),
    .bulletPosX(bulletPosX), .bulletPosY(bulletPosY), .active(active),
    .busy(busy), .hitPlayer(hitPlayer), .missed(missed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Trajectory model: walk the rows one by one and apply the hit / floor rules
  function automatic void model(input int sx, input int px, output bit hit,
                                output int k, output int y);
    hit = 1'b0; k = 0; y = SPAWN_Y;
    for (int s = 1; s <= FLOOR_Y - SPAWN_Y; s++) begin
      int yy;
      yy = SPAWN_Y + s;
      if (yy >= PLAYER_Y && yy < PLAYER_Y + HIT_H && sx >= px && sx < px + PLAYER_W) begin
        hit = 1'b1; k = s; y = yy; return;
      end
      if (yy == FLOOR_Y) begin
        k = s; y = yy; return;
      end
    end
  endfunction

  // One complete shot from IDLE back to IDLE, with an optional playerX change
  task automatic fly(input string name, input logic [9:0] sx, input logic [9:0] px,
                     input bit exp_hit, input int exp_k, input int exp_y,
                     input int move_cyc, input logic [9:0] move_px);
    int   pulse_cyc, pulses, idle_cyc, got_y, idle_y;
    bit   got_hit;
    logic act_at_pulse, act_after;
    pulse_cyc = -1; pulses = 0; idle_cyc = -1; got_y = 0; idle_y = 0;
    got_hit = 1'b0; act_at_pulse = 1'b0; act_after = 1'b1;
    @(negedge clk);
    fire = 1'b1; spawnX = sx; playerX = px;
    @(posedge clk); #1;
    fire = 1'b0;
    chk({name, " launch active"}, active, 1);
    chk({name, " launch busy"}, busy, 1);
    chk({name, " launch x"}, bulletPosX, sx);
    chk({name, " launch y"}, bulletPosY, SPAWN_Y);
    for (int c = 1; c <= 200 && idle_cyc < 0; c++) begin
      if (c == move_cyc) playerX = move_px;
      @(posedge clk); #1;
      if (hitPlayer || missed) begin
        pulses++;
        if (pulse_cyc < 0) begin
          pulse_cyc = c; got_hit = hitPlayer; got_y = bulletPosY; act_at_pulse = active;
        end
      end
      if (pulse_cyc >= 0 && c == pulse_cyc + 1) act_after = active;
      if (!busy) begin
        idle_cyc = c; idle_y = bulletPosY;
      end
    end
    if (idle_cyc < 0) chk({name, " busy timeout"}, 0, 1);
    chk({name, " pulse cycle"}, pulse_cyc, STEP_DIV * exp_k);
    chk({name, " hit vs miss"}, got_hit, exp_hit);
    chk({name, " terminal y"}, got_y, exp_y);
    chk({name, " pulse count"}, pulses, 1);
    chk({name, " active at pulse"}, act_at_pulse, 1);
    chk({name, " active after pulse"}, act_after, 0);
    chk({name, " idle cycle"}, idle_cyc, STEP_DIV * exp_k + 1 + COOL_CYC);
    chk({name, " idle y"}, idle_y, SPAWN_Y);
  endtask

  typedef struct {
    logic [9:0] sx;
    logic [9:0] px;
    bit         hit;
    int         k;
    int         y;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int   found;
    bit   m_hit;
    int   m_k, m_y;
    logic [9:0] rsx, rpx;

    vecs[0] = '{10'd50,   10'd46,   1'b1, 6,  106};
    vecs[1] = '{10'd50,   10'd200,  1'b0, 10, 110};
    vecs[2] = '{10'd54,   10'd46,   1'b0, 10, 110};
    vecs[3] = '{10'd46,   10'd46,   1'b1, 6,  106};
    vecs[4] = '{10'd53,   10'd46,   1'b1, 6,  106};
    vecs[5] = '{10'd45,   10'd46,   1'b0, 10, 110};
    vecs[6] = '{10'd0,    10'd0,    1'b1, 6,  106};
    vecs[7] = '{10'd1023, 10'd1020, 1'b1, 6,  106};
    vecs[8] = '{10'd3,    10'd1020, 1'b0, 10, 110};

    reset = 1'b1; fire = 1'b0; spawnX = '0; playerX = '0;
    #2 reset = 1'b0;
    #1;
    chk("reset x", bulletPosX, 0);
    chk("reset y", bulletPosY, SPAWN_Y);
    chk("reset active", active, 0);
    chk("reset busy", busy, 0);
    chk("reset hit", hitPlayer, 0);
    chk("reset miss", missed, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i])
      fly($sformatf("vec%0d", i), vecs[i].sx, vecs[i].px, vecs[i].hit, vecs[i].k,
          vecs[i].y, -1, 10'd0);

    // Late player move into the column two cycles before the step to row 106
    fly("late move", 10'd50, 10'd200, 1'b1, 6, 106, 23, 10'd46);

    // Fire while busy is ignored; fire held through cooldown relaunches at once
    @(negedge clk);
    fire = 1'b1; spawnX = 10'd50; playerX = 10'd46;
    @(posedge clk); #1;
    fire = 1'b0;
    found = -1;
    for (int c = 1; c <= 100 && found < 0; c++) begin
      if (c == 10) begin
        fire = 1'b1; spawnX = 10'd300;
      end
      @(posedge clk); #1;
      if (c == 11) chk("busy fire ignored x", bulletPosX, 50);
      if (!busy) found = c;
    end
    chk("held fire idle cycle", found, STEP_DIV * 6 + 1 + COOL_CYC);
    chk("held fire idle y", bulletPosY, SPAWN_Y);
    @(posedge clk); #1;
    chk("relaunch active", active, 1);
    chk("relaunch busy", busy, 1);
    chk("relaunch x", bulletPosX, 300);
    chk("relaunch y", bulletPosY, SPAWN_Y);
    fire = 1'b0;

    // Asynchronous reset mid-flight at row 103
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(posedge clk); #1;
      if (bulletPosY == 10'd103) found = 1;
    end
    chk("reach row 103", found, 1);
    #2 reset = 1'b0;
    #1;
    chk("async reset x", bulletPosX, 0);
    chk("async reset y", bulletPosY, SPAWN_Y);
    chk("async reset active", active, 0);
    chk("async reset busy", busy, 0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("reset no pulse", hitPlayer | missed, 0);
    end
    @(negedge clk);
    reset = 1'b1;
    fly("after reset", 10'd50, 10'd46, 1'b1, 6, 106, -1, 10'd0);

    // Random shots against the trajectory model
    for (int r = 0; r < 10; r++) begin
      rsx = 10'($urandom_range(0, 1023));
      rpx = 10'((int'(rsx) + 1024 - int'($urandom_range(0, 12))) % 1024);
      model(int'(rsx), int'(rpx), m_hit, m_k, m_y);
      fly($sformatf("rand%0d sx=%0d px=%0d", r, rsx, rpx), rsx, rpx, m_hit, m_k, m_y,
          -1, 10'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
